// File: rtl/store_packer_pkg.sv
// Shared definitions for the sub-word store unit.
//   size_e     : req_size encodings (byte/half/word, 11 reserved)
//   state_e    : store_packer FSM states
//   bad_request: misalignment / reserved-size check applied at accept time
package store_packer_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } state_e;

  // 1 when the request must be retired with err and no memory access.
  function automatic logic bad_request(size_e size, logic [1:0] low);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return low[0];
      SIZE_WORD: return |low;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_packer_byte_lane_merge.sv
// byte_lane_merge: combinational insert of a byte/halfword into a 32-bit word.
//   old_word   in  32  word read back from memory
//   data       in  16  store data (byte uses [7:0], half uses [15:0])
//   size       in  2   SIZE_BYTE / SIZE_HALF; anything else passes old_word through
//   lane       in  2   byte offset addr[1:0] (half uses lane[1])
//   big_endian in  1   1: offset 0 is bits[31:24]; 0: offset 0 is bits[7:0]
//   new_word   out 32  merged word
module byte_lane_merge
  import store_packer_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] data,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        big_endian,
  output logic [31:0] new_word
);

  logic [1:0] byte_pos;

  // Bit position of the addressed byte, counted from bits[7:0].
  assign byte_pos = big_endian ? ~lane : lane;

  always_comb begin
    new_word = old_word;
    case (size)
      SIZE_BYTE: new_word[{byte_pos, 3'b000} +: 8] = data[7:0];
      SIZE_HALF: begin
        // Upper half for BE offset 0 or LE offset 2.
        if (lane[1] ^ big_endian) new_word[31:16] = data;
        else                      new_word[15:0]  = data;
      end
      default: new_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_packer.sv
// store_packer: sub-word store unit for a word-only data memory.
// sw is a single write; sb/sh are read-modify-write. The CPU stalls while busy.
//   clk, rst           clock (rising) / asynchronous active-high reset
//   req_valid/ready    request handshake; ready only when idle
//   req_size           00 byte, 01 half, 10 word, 11 reserved (error)
//   req_addr/wdata     byte address / store data
//   done, err          one-cycle retire pulse; err qualifies done
//   mem_addr           word-aligned address, held through the access
//   mem_rd/mem_rdata   read strobe / data valid MEM_LAT cycles later
//   mem_wr/mem_wdata   write strobe / merged write word
module store_packer
  import store_packer_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wword_q;
  logic [15:0] data_q;
  logic [1:0]  lane_q;
  size_e       size_q;
  logic        err_q;
  size_e       req_size_e;
  logic        req_bad;
  logic [31:0] merged;

  assign req_size_e = size_e'(req_size);
  assign req_bad    = bad_request(req_size_e, req_addr[1:0]);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wword_q;

  byte_lane_merge u_merge (
    .old_word  (wword_q),
    .data      (data_q),
    .size      (size_q),
    .lane      (lane_q),
    .big_endian(BIG_ENDIAN),
    .new_word  (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Dispatch (error / word / sub-word) is decided on the accept edge itself,
  // so the check step costs no cycle of its own.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                      state_d = ST_DONE;
          else if (req_size_e == SIZE_WORD) state_d = ST_WRITE;
          else                              state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_rd  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT:  if (cnt_q == 3'd0) state_d = ST_MERGE;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: begin
        mem_wr  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // wword_q holds the sw data directly, or the read word that MERGE then
  // overwrites in place with the merged result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wword_q <= '0;
      data_q  <= '0;
      lane_q  <= '0;
      size_q  <= SIZE_BYTE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q <= {req_addr[31:2], 2'b00};
            lane_q <= req_addr[1:0];
            size_q <= req_size_e;
            data_q <= req_wdata[15:0];
            err_q  <= req_bad;
            if (!req_bad && req_size_e == SIZE_WORD) wword_q <= req_wdata;
          end
        end
        ST_READ: cnt_q <= LAT_LOAD;
        ST_WAIT: begin
          if (cnt_q == 3'd0) wword_q <= mem_rdata;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        ST_MERGE: wword_q <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_packer.sv
// Testbench for store_packer: a big-endian instance with MEM_LAT=3 and a
// little-endian instance with MEM_LAT=1 share the request inputs, each with
// its own word memory model that returns random noise outside the valid slot.
module tb_store_packer;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req_valid;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;
  logic [1:0]       req_ready, done, err, mem_rd, mem_wr;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

  store_packer #(.MEM_LAT(LAT0), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done[0]), .err(err[0]), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
    .mem_rdata(mem_rdata[0]), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]));

  store_packer #(.MEM_LAT(LAT1), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done[1]), .err(err[1]), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
    .mem_rdata(mem_rdata[1]), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]));

  function automatic int lat(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit big(int d);
    return d == 0;
  endfunction

  // ---------------- memory models and monitors ----------------
  logic [31:0] mem [2][1024];
  int          cyc;
  bit   [31:0] noise;
  int          rcyc [2];
  bit          rpend [2];
  logic [9:0]  ridx [2];
  int          rd_n [2], wr_n [2], done_n [2], err_n [2], stray_err [2];
  int          done_cyc [2], rd_cyc [2], wr_cyc [2];
  logic [31:0] wr_addr [2], rd_addr [2];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  always_comb begin
    mem_rdata = '0;
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (rpend[d] && cyc == rcyc[d] + lat(d)) ? mem[d][ridx[d]] : noise;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= $urandom;
    for (int d = 0; d < 2; d++) begin
      if (pre_en) mem[d][pre_idx] <= pre_val;
      if (mem_rd[d]) begin
        rpend[d]   <= 1'b1;
        rcyc[d]    <= cyc;
        ridx[d]    <= mem_addr[d][11:2];
        rd_n[d]    <= rd_n[d] + 1;
        rd_cyc[d]  <= cyc;
        rd_addr[d] <= mem_addr[d];
      end
      if (mem_wr[d]) begin
        mem[d][mem_addr[d][11:2]] <= mem_wdata[d];
        wr_n[d]    <= wr_n[d] + 1;
        wr_cyc[d]  <= cyc;
        wr_addr[d] <= mem_addr[d];
      end
      if (done[d]) begin
        done_n[d]   <= done_n[d] + 1;
        done_cyc[d] <= cyc;
        if (err[d]) err_n[d] <= err_n[d] + 1;
      end
      if (err[d] && !done[d]) stray_err[d] <= stray_err[d] + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic ref_err(logic [1:0] size, logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  // Store bytes addr..addr+n-1 into the word using memory byte order:
  // BE puts the most significant data byte at the lowest address.
  function automatic logic [31:0] ref_word(int d, logic [1:0] size, logic [31:0] addr,
                                           logic [31:0] wdata, logic [31:0] old);
    logic [31:0] w;
    int n, off, src, pos;
    w = old;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      off = int'(addr[1:0]) + i;
      src = big(d) ? (n - 1 - i) : i;
      pos = big(d) ? (3 - off) : off;
      w[pos*8 +: 8] = wdata[src*8 +: 8];
    end
    return w;
  endfunction

  // ---------------- checking ----------------
  int checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] old);
    int a, t, l;
    int rd0 [2], wr0 [2], dn0 [2], er0 [2];
    logic e, sub;
    logic [9:0] idx;
    logic [31:0] wa;
    idx = addr[11:2];
    wa  = {addr[31:2], 2'b00};
    e   = ref_err(size, addr);
    sub = !e && (size != 2'b10);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = old;
    @(negedge clk);
    pre_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd0[d] = rd_n[d]; wr0[d] = wr_n[d]; dn0[d] = done_n[d]; er0[d] = err_n[d];
    end
    chk($sformatf("%s_ready", tag), 32'(req_ready), 32'h3);
    req_valid = 1'b1; req_size = size; req_addr = addr; req_wdata = wdata;
    a = cyc;
    @(negedge clk);
    chk($sformatf("%s_busy", tag), 32'(req_ready), 32'h0);
    // Valid stays high with scrambled fields while busy: must be ignored.
    req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!(done_n[0] == dn0[0] + 1 && done_n[1] == dn0[1] + 1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      l = e ? 1 : (size == 2'b10) ? 2 : 4 + lat(d);
      chk($sformatf("%s_d%0d_done_cnt", tag, d), 32'(done_n[d] - dn0[d]), 32'd1);
      chk($sformatf("%s_d%0d_err", tag, d), 32'(err_n[d] - er0[d]), 32'(e));
      chk($sformatf("%s_d%0d_latency", tag, d), 32'(done_cyc[d] - a), 32'(l));
      chk($sformatf("%s_d%0d_word", tag, d), mem[d][idx],
          e ? old : ref_word(d, size, addr, wdata, old));
      chk($sformatf("%s_d%0d_rd_cnt", tag, d), 32'(rd_n[d] - rd0[d]), 32'(sub));
      chk($sformatf("%s_d%0d_wr_cnt", tag, d), 32'(wr_n[d] - wr0[d]), 32'(!e));
      if (!e) chk($sformatf("%s_d%0d_wr_addr", tag, d), wr_addr[d], wa);
      if (sub) begin
        chk($sformatf("%s_d%0d_rd_addr", tag, d), rd_addr[d], wa);
        chk($sformatf("%s_d%0d_rd_to_wr", tag, d), 32'(wr_cyc[d] - rd_cyc[d]), 32'(lat(d) + 2));
      end
    end
  endtask

  task automatic reset_mid_op();
    int t;
    int rd0 [2], wr0 [2];
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 10'h010; pre_val = 32'hA5A5_5A5A;
    @(negedge clk);
    pre_en = 1'b0;
    for (int d = 0; d < 2; d++) begin rd0[d] = rd_n[d]; wr0[d] = wr_n[d]; end
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h41; req_wdata = 32'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (rd_n[0] == rd0[0] && t < 20) begin @(negedge clk); t++; end
    chk("rstwait_rd_seen", 32'(rd_n[0] - rd0[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwait_ready", 32'(req_ready), 32'h3);
    chk("rstwait_strobes", {28'd0, mem_rd, mem_wr}, 32'h0);
    chk("rstwait_done_err", {28'd0, done, err}, 32'h0);
    chk("rstwait_addr_be", mem_addr[0], 32'h0);
    chk("rstwait_wdata_be", mem_wdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) rd0[d] = rd_n[d];
    repeat (12) @(negedge clk);
    chk("rstwait_ready_after", 32'(req_ready), 32'h3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rstwait_d%0d_no_rd", d), 32'(rd_n[d] - rd0[d]), 32'd0);
      chk($sformatf("rstwait_d%0d_no_wr", d), 32'(wr_n[d] - wr0[d]), 32'd0);
      chk($sformatf("rstwait_d%0d_word", d), mem[d][10'h010], 32'hA5A5_5A5A);
    end
  endtask

  task automatic back_to_back();
    int a, t;
    int dn0 [2], wr0 [2];
    for (int d = 0; d < 2; d++) begin dn0[d] = done_n[d]; wr0[d] = wr_n[d]; end
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h500; req_wdata = 32'h1111_2222;
    a = cyc;
    @(negedge clk);
    req_addr = 32'h504; req_wdata = 32'h3333_4444;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!(done_n[0] == dn0[0] + 2 && done_n[1] == dn0[1] + 2) && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("b2b_d%0d_done_cnt", d), 32'(done_n[d] - dn0[d]), 32'd2);
      chk($sformatf("b2b_d%0d_second_done", d), 32'(done_cyc[d] - a), 32'd5);
      chk($sformatf("b2b_d%0d_wr_cnt", d), 32'(wr_n[d] - wr0[d]), 32'd2);
      chk($sformatf("b2b_d%0d_word0", d), mem[d][10'h140], 32'h1111_2222);
      chk($sformatf("b2b_d%0d_word1", d), mem[d][10'h141], 32'h3333_4444);
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] old;
    logic [31:0] exp_be;
    logic [31:0] exp_le;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [9];
    logic [1:0]  rs;
    logic [31:0] ra;
    vt[0] = '{2'b10, 32'h100, 32'hDEAD_BEEF, 32'h5555_5555, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[1] = '{2'b00, 32'h203, 32'h0000_00AA, 32'h1122_3344, 32'h1122_33AA, 32'hAA22_3344};
    vt[2] = '{2'b01, 32'h202, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, 32'hBEEF_3344};
    vt[3] = '{2'b01, 32'h201, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_3344, 32'h1122_3344};
    vt[4] = '{2'b11, 32'h200, 32'h1234_5678, 32'h1122_3344, 32'h1122_3344, 32'h1122_3344};
    vt[5] = '{2'b00, 32'h000, 32'hFFFF_FF5A, 32'h0102_0304, 32'h5A02_0304, 32'h0102_035A};
    vt[6] = '{2'b01, 32'h200, 32'h1234_CAFE, 32'h1122_3344, 32'hCAFE_3344, 32'h1122_CAFE};
    vt[7] = '{2'b10, 32'h306, 32'h7777_7777, 32'h9999_9999, 32'h9999_9999, 32'h9999_9999};
    vt[8] = '{2'b00, 32'h201, 32'h0000_0077, 32'h1122_3344, 32'h1177_3344, 32'h1122_7744};

    rst = 1'b1; req_valid = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h3);
    chk("reset_strobes", {28'd0, mem_rd, mem_wr}, 32'h0);
    chk("reset_done_err", {28'd0, done, err}, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_d%0d_mem_addr", d), mem_addr[d], 32'h0);
      chk($sformatf("reset_d%0d_mem_wdata", d), mem_wdata[d], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].size, vt[i].addr, vt[i].wdata, vt[i].old);
      chk($sformatf("vec%0d_be_table", i), mem[0][vt[i].addr[11:2]], vt[i].exp_be);
      chk($sformatf("vec%0d_le_table", i), mem[1][vt[i].addr[11:2]], vt[i].exp_le);
    end

    reset_mid_op();
    run_op("post_rst_sw", 2'b10, 32'h44, 32'hC0FF_EE00, 32'h1234_5678);

    back_to_back();

    for (int i = 0; i < 60; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom & 32'h0000_0FFF;
      run_op($sformatf("rnd%0d", i), rs, ra, $urandom, $urandom);
    end

    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d_err_without_done", d), 32'(stray_err[d]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
